mac_arbiter: RTL and testbench

Shares the single SB_MAC16 multiply-accumulate datapath between NREQ independent requesters, such as the CPU misc-register port and a hardware audio filter. Each requester hands over one (A×B ± ACCUM) operation with a valid/ready handshake and gets its result back with a one-cycle response pulse. The block does round-robin arbitration, supports a lock for uninterrupted accumulate chains, sequences the MAC operand-load strobe, and waits out the MAC latency. It sits between the requesters and the DSP-block wrapper.

---
 rtl/mac_defs_pkg.sv | 30 +++
 rtl/rr_arbiter.sv | 35 +++
 rtl/mac_arbiter.sv | 174 +++++++++++++++++
 tb/tb_mac_arbiter.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_defs_pkg.sv
// Shared definitions for the MAC arbiter: FSM encoding, operand width and
// per-requester index/slice helpers.
package mac_defs_pkg;

    localparam int OPW = 16;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_e;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int next_idx(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

    function automatic int op_lo(input int r);
        return r * OPW;
    endfunction

    function automatic int word_lo(input int r, input int w);
        return r * w;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first eligible requester at or above ptr,
// wrapping; the mask restricts eligibility to the lock owner.
module rr_arbiter
    import mac_defs_pkg::*;
#(
    parameter int NREQ = 2
) (
    input  logic [NREQ-1:0]              req_i,
    input  logic [idx_width(NREQ)-1:0]   ptr_i,
    input  logic [NREQ-1:0]              mask_i,
    output logic [NREQ-1:0]              gnt_o
);

    logic [NREQ-1:0] elig;

    assign elig = req_i & mask_i;

    // Walk from the farthest candidate back to ptr so the last hit has priority.
    always_comb begin
        int idx;
        idx   = 0;
        gnt_o = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            idx = int'(ptr_i) + i;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (elig[idx]) begin
                gnt_o      = '0;
                gnt_o[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mac_arbiter.sv
// Round-robin sharing of one MAC datapath between NREQ requesters, with
// lockable accumulate chains and fixed-latency result capture.
module mac_arbiter
    import mac_defs_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int LAT  = 1,
    parameter int DW   = 32
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_reset_ni,
    input  logic [NREQ-1:0]      req_valid_i,
    output logic [NREQ-1:0]      req_ready_o,
    input  logic [NREQ*OPW-1:0]  req_op_a_i,
    input  logic [NREQ*OPW-1:0]  req_op_b_i,
    input  logic [NREQ*DW-1:0]   req_accum_i,
    input  logic [NREQ-1:0]      req_sub_i,
    input  logic [NREQ-1:0]      req_chain_i,
    input  logic [NREQ-1:0]      req_lock_i,
    output logic [NREQ-1:0]      rsp_valid_o,
    output logic [DW-1:0]        rsp_data_o,
    output logic                 rsp_carry_o,
    output logic [OPW-1:0]       mac_a_o,
    output logic [OPW-1:0]       mac_b_o,
    output logic [DW-1:0]        mac_accum_o,
    output logic                 mac_sub_o,
    output logic                 mac_load_o,
    input  logic [DW-1:0]        mac_result_i,
    input  logic                 mac_carry_i,
    output logic                 busy_o
);

    localparam int PW = idx_width(NREQ);
    localparam int CW = idx_width(LAT);

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [PW-1:0]   ptr_q;
    logic            lock_v_q;
    logic [PW-1:0]   lock_own_q;
    logic [PW-1:0]   gnt_q;
    logic            lock_req_q;
    logic [OPW-1:0]  mac_a_q, mac_b_q;
    logic [DW-1:0]   mac_accum_q;
    logic            mac_sub_q;
    logic [DW-1:0]   res_q;
    logic            carry_q;

    logic [PW-1:0]   arb_ptr, arb_own, win;
    logic            arb_lock, arb_en, hs;
    logic [NREQ-1:0] lock_mask, grant;

    // In RESP the arbiter already sees the pointer/lock this operation leaves behind.
    always_comb begin
        arb_ptr  = ptr_q;
        arb_own  = lock_own_q;
        arb_lock = lock_v_q;
        if (state_q == S_RESP) begin
            arb_ptr  = PW'(next_idx(int'(gnt_q), NREQ));
            arb_own  = gnt_q;
            arb_lock = lock_req_q;
        end
        lock_mask = '1;
        if (arb_lock) begin
            lock_mask          = '0;
            lock_mask[arb_own] = 1'b1;
        end
    end

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_rr (
        .req_i  (req_valid_i),
        .ptr_i  (arb_ptr),
        .mask_i (lock_mask),
        .gnt_o  (grant)
    );

    always_comb begin
        win = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                win = PW'(i);
            end
        end
    end

    assign arb_en      = (state_q == S_IDLE) || (state_q == S_RESP);
    assign req_ready_o = arb_en ? grant : '0;
    assign hs          = |(req_valid_i & req_ready_o);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (hs) begin
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_d   = CW'(LAT - 1);
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_RESP: begin
                state_d = hs ? S_ISSUE : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_reset_ni) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            ptr_q       <= '0;
            lock_v_q    <= 1'b0;
            lock_own_q  <= '0;
            gnt_q       <= '0;
            lock_req_q  <= 1'b0;
            mac_a_q     <= '0;
            mac_b_q     <= '0;
            mac_accum_q <= '0;
            mac_sub_q   <= 1'b0;
            res_q       <= '0;
            carry_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (hs) begin
                mac_a_q     <= req_op_a_i[op_lo(int'(win)) +: OPW];
                mac_b_q     <= req_op_b_i[op_lo(int'(win)) +: OPW];
                mac_sub_q   <= req_sub_i[win];
                mac_accum_q <= req_chain_i[win] ? res_q
                                                : req_accum_i[word_lo(int'(win), DW) +: DW];
                gnt_q       <= win;
                lock_req_q  <= req_lock_i[win];
            end
            if (state_q == S_WAIT && cnt_q == '0) begin
                res_q   <= mac_result_i;
                carry_q <= mac_carry_i;
            end
            if (state_q == S_RESP) begin
                ptr_q      <= arb_ptr;
                lock_v_q   <= arb_lock;
                lock_own_q <= arb_own;
            end
        end
    end

    always_comb begin
        rsp_valid_o = '0;
        if (state_q == S_RESP) begin
            rsp_valid_o[gnt_q] = 1'b1;
        end
    end

    assign rsp_data_o  = res_q;
    assign rsp_carry_o = carry_q;
    assign mac_a_o     = mac_a_q;
    assign mac_b_o     = mac_b_q;
    assign mac_accum_o = mac_accum_q;
    assign mac_sub_o   = mac_sub_q;
    assign mac_load_o  = (state_q == S_ISSUE);
    assign busy_o      = (state_q != S_IDLE);

endmodule

// File: tb/tb_mac_arbiter.sv
// Directed bench for mac_arbiter: one LAT=1 instance for the main sequence,
// one LAT=3 instance for the reset-in-WAIT case, each with a latency MAC model.
module tb_mac_arbiter;

    logic        clk = 1'b0;
    logic        rst_n, rst3_n;
    logic [1:0]  vld, vld3;
    logic [31:0] op_a, op_b;
    logic [63:0] acc;
    logic [1:0]  sub, chain, lock;

    logic [1:0]  rdy1, rv1, rdy3, rv3;
    logic [31:0] rd1, rd3, macc1, macc3, mres1, mres3;
    logic        rc1, rc3, msub1, msub3, mload1, mload3, busy1, busy3, mcar1, mcar3;
    logic [15:0] ma1, mb1, ma3, mb3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mac_arbiter #(.NREQ(2), .LAT(1), .DW(32)) u_dut (
        .wb_clk_i(clk), .wb_reset_ni(rst_n),
        .req_valid_i(vld), .req_ready_o(rdy1),
        .req_op_a_i(op_a), .req_op_b_i(op_b), .req_accum_i(acc),
        .req_sub_i(sub), .req_chain_i(chain), .req_lock_i(lock),
        .rsp_valid_o(rv1), .rsp_data_o(rd1), .rsp_carry_o(rc1),
        .mac_a_o(ma1), .mac_b_o(mb1), .mac_accum_o(macc1), .mac_sub_o(msub1),
        .mac_load_o(mload1), .mac_result_i(mres1), .mac_carry_i(mcar1),
        .busy_o(busy1)
    );

    mac_arbiter #(.NREQ(2), .LAT(3), .DW(32)) u_dut3 (
        .wb_clk_i(clk), .wb_reset_ni(rst3_n),
        .req_valid_i(vld3), .req_ready_o(rdy3),
        .req_op_a_i(op_a), .req_op_b_i(op_b), .req_accum_i(acc),
        .req_sub_i(sub), .req_chain_i(chain), .req_lock_i(lock),
        .rsp_valid_o(rv3), .rsp_data_o(rd3), .rsp_carry_o(rc3),
        .mac_a_o(ma3), .mac_b_o(mb3), .mac_accum_o(macc3), .mac_sub_o(msub3),
        .mac_load_o(mload3), .mac_result_i(mres3), .mac_carry_i(mcar3),
        .busy_o(busy3)
    );

    function automatic logic [32:0] mac_model(input logic [31:0] c, input logic [15:0] a,
                                              input logic [15:0] b, input logic s);
        logic [32:0] prod;
        prod = {17'b0, a} * {17'b0, b};
        return s ? ({1'b0, c} - prod) : ({1'b0, c} + prod);
    endfunction

    // MAC models: result is only meaningful exactly LAT cycles after the load.
    logic [32:0] m1_val = '0;
    logic [32:0] m3_val = '0;
    int          m1_dly = 0;
    int          m3_dly = 0;

    always @(posedge clk) begin
        if (mload1) begin
            m1_val <= mac_model(macc1, ma1, mb1, msub1);
            m1_dly <= 1;
        end else if (m1_dly > 0) begin
            m1_dly <= m1_dly - 1;
        end
        if (mload3) begin
            m3_val <= mac_model(macc3, ma3, mb3, msub3);
            m3_dly <= 3;
        end else if (m3_dly > 0) begin
            m3_dly <= m3_dly - 1;
        end
    end

    assign mres1 = (m1_dly == 1) ? m1_val[31:0] : 32'hDEAD_BEEF;
    assign mcar1 = (m1_dly == 1) ? m1_val[32] : 1'b0;
    assign mres3 = (m3_dly == 1) ? m3_val[31:0] : 32'hDEAD_BEEF;
    assign mcar3 = (m3_dly == 1) ? m3_val[32] : 1'b0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %-16s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic set_req(input int r, input logic [15:0] a, input logic [15:0] b,
                           input logic [31:0] c, input logic s, input logic ch, input logic lk);
        op_a[r*16 +: 16] = a;
        op_b[r*16 +: 16] = b;
        acc[r*32 +: 32]  = c;
        sub[r]           = s;
        chain[r]         = ch;
        lock[r]          = lk;
    endtask

    initial begin
        rst_n = 1'b0; rst3_n = 1'b0;
        vld = '0; vld3 = '0;
        op_a = '0; op_b = '0; acc = '0; sub = '0; chain = '0; lock = '0;
        repeat (3) step();
        chk("rst_ready", rdy1, 2'b00);
        chk("rst_rsp", rv1, 2'b00);
        chk("rst_busy", busy1, 1'b0);
        chk("rst_load", mload1, 1'b0);
        chk("rst_mac_a", ma1, 16'h0);
        chk("rst_accum", macc1, 32'h0);
        chk("rst_data", rd1, 32'h0);
        chk("rst_carry", rc1, 1'b0);
        rst_n = 1'b1;
        step();

        // Single op: 3*5+7 = 22
        set_req(0, 16'd3, 16'd5, 32'd7, 1'b0, 1'b0, 1'b0);
        vld = 2'b01; #1;
        chk("t1_ready", rdy1, 2'b01);
        step(); vld = 2'b00; #1;
        chk("t1_load", mload1, 1'b1);
        chk("t1_mac_a", ma1, 16'd3);
        chk("t1_mac_b", mb1, 16'd5);
        chk("t1_accum", macc1, 32'd7);
        chk("t1_busy", busy1, 1'b1);
        step();
        chk("t1_load_off", mload1, 1'b0);
        chk("t1_no_rsp", rv1, 2'b00);
        step();
        chk("t1_rsp", rv1, 2'b01);
        chk("t1_data", rd1, 32'd22);
        chk("t1_carry", rc1, 1'b0);
        step();
        chk("t1_rsp_off", rv1, 2'b00);
        chk("t1_hold", rd1, 32'd22);
        chk("t1_idle", busy1, 1'b0);

        // Subtract with borrow on r1: 4 - 2*3 = -2
        set_req(1, 16'd2, 16'd3, 32'd4, 1'b1, 1'b0, 1'b0);
        vld = 2'b10; #1;
        chk("t2_ready", rdy1, 2'b10);
        step(); vld = 2'b00; #1;
        chk("t2_sub", msub1, 1'b1);
        step(); step();
        chk("t2_rsp", rv1, 2'b10);
        chk("t2_data", rd1, 32'hFFFF_FFFE);
        chk("t2_carry", rc1, 1'b1);
        step();

        // Round robin, back-to-back every 3 cycles: r0 -> 101, r1 -> 60
        set_req(0, 16'd10, 16'd10, 32'd1, 1'b0, 1'b0, 1'b0);
        set_req(1, 16'd20, 16'd3, 32'd0, 1'b0, 1'b0, 1'b0);
        vld = 2'b11; #1;
        chk("rr_g0", rdy1, 2'b01);
        step();
        chk("rr_busy_stall", rdy1, 2'b00);
        step(); step();
        chk("rr_rsp0", rv1, 2'b01);
        chk("rr_data0", rd1, 32'd101);
        chk("rr_g1", rdy1, 2'b10);
        repeat (3) step();
        chk("rr_rsp1", rv1, 2'b10);
        chk("rr_data1", rd1, 32'd60);
        chk("rr_g2", rdy1, 2'b01);
        repeat (3) step();
        chk("rr_rsp2", rv1, 2'b01);
        chk("rr_g3", rdy1, 2'b10);
        step(); vld = 2'b00;
        step(); step();
        chk("rr_rsp3", rv1, 2'b10);
        chk("rr_data3", rd1, 32'd60);
        chk("rr_none", rdy1, 2'b00);
        step();

        // Lock chain on r1 with r0 waiting: 1+2*2 = 5, then 5+3*3 = 14
        set_req(1, 16'd2, 16'd2, 32'd1, 1'b0, 1'b0, 1'b1);
        vld = 2'b10; #1;
        chk("lk_ready", rdy1, 2'b10);
        step();
        set_req(1, 16'd3, 16'd3, 32'h0000_FFFF, 1'b0, 1'b1, 1'b0);
        set_req(0, 16'd1, 16'd1, 32'd100, 1'b0, 1'b0, 1'b0);
        vld = 2'b11;
        step(); step();
        chk("lk_rsp0", rv1, 2'b10);
        chk("lk_data0", rd1, 32'd5);
        chk("lk_hold", rdy1, 2'b10);
        step(); vld = 2'b01; #1;
        chk("lk_chain_fwd", macc1, 32'd5);
        chk("lk_load", mload1, 1'b1);
        step(); step();
        chk("lk_rsp1", rv1, 2'b10);
        chk("lk_data1", rd1, 32'd14);
        chk("lk_release", rdy1, 2'b01);
        step(); vld = 2'b00;
        step(); step();
        chk("lk_r0_rsp", rv1, 2'b01);
        chk("lk_r0_data", rd1, 32'd101);
        step();

        // Valid withdrawn by r0 while busy with r1 (4*5 = 20)
        set_req(1, 16'd4, 16'd5, 32'd0, 1'b0, 1'b0, 1'b0);
        vld = 2'b10; #1;
        chk("wd_r1_ready", rdy1, 2'b10);
        step(); vld = 2'b01; #1;
        chk("wd_no_ready", rdy1, 2'b00);
        step(); vld = 2'b00; #1;
        chk("wd_no_ready2", rdy1, 2'b00);
        step();
        chk("wd_rsp_r1", rv1, 2'b10);
        chk("wd_data", rd1, 32'd20);
        step();
        chk("wd_no_rsp", rv1, 2'b00);
        chk("wd_idle", busy1, 1'b0);
        vld = 2'b11; #1;
        chk("wd_ptr", rdy1, 2'b01);
        step(); vld = 2'b00;
        step(); step();
        chk("wd_r0_rsp", rv1, 2'b01);
        chk("wd_r0_data", rd1, 32'd101);
        step();

        // Reset during WAIT on the LAT=3 instance
        rst3_n = 1'b1;
        step();
        set_req(1, 16'd2, 16'd2, 32'd2, 1'b0, 1'b0, 1'b0);
        vld3 = 2'b10; #1;
        chk("r3_ready", rdy3, 2'b10);
        step(); vld3 = 2'b00; #1;
        chk("r3_load", mload3, 1'b1);
        step(); rst3_n = 1'b0; #1;
        chk("r3_busy", busy3, 1'b1);
        step();
        chk("r3_rst_rsp", rv3, 2'b00);
        chk("r3_rst_busy", busy3, 1'b0);
        chk("r3_rst_load", mload3, 1'b0);
        chk("r3_rst_a", ma3, 16'h0);
        chk("r3_rst_b", mb3, 16'h0);
        chk("r3_rst_accum", macc3, 32'h0);
        chk("r3_rst_sub", msub3, 1'b0);
        chk("r3_rst_data", rd3, 32'h0);
        chk("r3_rst_carry", rc3, 1'b0);
        rst3_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("r3_no_rsp", rv3, 2'b00);
        end
        set_req(0, 16'd4, 16'd4, 32'd2, 1'b0, 1'b0, 1'b0);
        vld3 = 2'b11; #1;
        chk("r3_next_r0", rdy3, 2'b01);
        step(); vld3 = 2'b00; #1;
        chk("r3_load2", mload3, 1'b1);
        step(); step(); step();
        chk("r3_wait_rsp", rv3, 2'b00);
        step();
        chk("r3_rsp", rv3, 2'b01);
        chk("r3_data", rd3, 32'd18);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
